// File: rtl/cell_pos_reader.sv
// Read sequencer for one cell position memory: fetches the particle count at address 0,
// then streams records 1..N through a credit-tracked output FIFO. Optional count clamp: CELL_READER_COUNT_CLAMP_EN.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  last;
    } rec_t;

    state_t                                 state_q, state_d;
    logic [WW-1:0]                          wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]                  n_q, next_addr_q, next_addr_d, addr_hold_q;
    logic [RD_LATENCY-1:0]                  vld_pipe_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]  tag_pipe_q;
    rec_t                                   fifo_q [FIFO_DEPTH];
    logic [PW-1:0]                          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                          fifo_cnt_q, inflight;
    logic                                   issue, tag_in, push, pop, cnt_latch;
    logic [ADDR_WIDTH-1:0]                  issue_addr, cnt_raw, cnt_use;
    rec_t                                   push_rec, head;

    assign cnt_raw = mem_q[ADDR_WIDTH-1:0];

`ifdef CELL_READER_COUNT_CLAMP_EN
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);
    logic err_q;
    assign cnt_use   = (cnt_raw > MAX_ADDR) ? MAX_ADDR : cnt_raw;
    assign count_err = err_q;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                          err_q <= 1'b0;
        else if (state_q == IDLE && start)   err_q <= 1'b0;
        else if (cnt_latch)                  err_q <= (cnt_raw > MAX_ADDR);
    end
`else
    assign cnt_use   = cnt_raw;
    assign count_err = 1'b0;
`endif

    // Reads still in the memory pipe count against FIFO space so a push always finds room.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        next_addr_d = next_addr_q;
        issue       = 1'b0;
        tag_in      = 1'b0;
        issue_addr  = next_addr_q;
        cnt_latch   = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = RD_CNT;
            RD_CNT: begin
                issue      = 1'b1;
                issue_addr = '0;
                wait_d     = '0;
                state_d    = WAIT_CNT;
            end
            WAIT_CNT: begin
                if (wait_q == WW'(RD_LATENCY - 1)) begin
                    cnt_latch = 1'b1;
                    if (cnt_use == '0) state_d = FIN;
                    else begin
                        next_addr_d = ADDR_WIDTH'(1);
                        state_d     = STREAM;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            STREAM: begin
                if (fifo_cnt_q + inflight < CW'(FIFO_DEPTH)) begin
                    issue       = 1'b1;
                    tag_in      = 1'b1;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    if (next_addr_q == n_q) state_d = DRAIN;
                end
            end
            DRAIN:   if (inflight == '0 && fifo_cnt_q == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign mem_rden    = issue;
    assign mem_address = issue ? issue_addr : addr_hold_q;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;
    assign particle_count = n_q;

    assign push     = vld_pipe_q[RD_LATENCY-1];
    assign push_rec = '{data: mem_q, idx: tag_pipe_q[RD_LATENCY-1],
                        last: (tag_pipe_q[RD_LATENCY-1] == n_q)};
    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign head      = fifo_q[rd_ptr_q];
    // Gated so every output reads zero while the FIFO is empty (including straight after reset).
    assign out_data  = out_valid ? head.data : '0;
    assign out_index = out_valid ? head.idx  : '0;
    assign out_last  = out_valid & head.last;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            next_addr_q <= '0;
            n_q         <= '0;
            addr_hold_q <= '0;
            vld_pipe_q  <= '0;
            tag_pipe_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            next_addr_q <= next_addr_d;
            if (cnt_latch) n_q <= cnt_use;
            if (issue)     addr_hold_q <= issue_addr;
            vld_pipe_q[0] <= tag_in;
            tag_pipe_q[0] <= next_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= push_rec;
    end

endmodule
